gate_truth_checker: RTL and testbench
=====================================

# gate_truth_checker

Self-checking truth-table sequencer for the combinational gates in the `gates/` library. It sits directly upstream and downstream of a gate under test. It drives every input combination onto the gate, samples the gate's output after a programmable settle time and compares it with the expected function. It then reports an error count, the first failing vector and a pass flag. The block lets the gate checks run clocked, in simulation or on a board, without hand-written vector lists.

## Interface

Parameters:
- `N_IN`, default 2: number of gate inputs driven (1–8).
- `SETTLE`, default 4: cycles each vector is held before X is sampled (≥1).

Ports:
- `CLK` input 1: single clock. All state updates on the rising edge.
- `RST` input 1: reset, asynchronous, active-high.
- `START` input 1: begin a run. Sampled only in IDLE.
- `OP` input 3: expected gate function, latched at accepted START.
  - 0=AND, 1=OR, 2=NAND, 3=NOR, 4=XOR, 5=XNOR.
- `VEC` output N_IN: stimulus to gate inputs. Bit 0 maps to A, bit 1 maps to B.
- `X` input 1: gate output under test.
- `BUSY` output 1: run in progress.
- `DONE` output 1: one-cycle pulse at end of run.
- `PASS` output 1: last run completed with zero mismatches.
- `ERR_CNT` output N_IN+1: mismatch count of the current or last run.
- `FIRST_FAIL` output N_IN: first mismatching vector. Meaningful only when ERR_CNT≠0.

## Operation

- FSM has two states, IDLE and RUN, plus a settle counter `cnt` (0..SETTLE-1) and a latched op `op_q`.
- **Reset**: state=IDLE, VEC=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FIRST_FAIL=0, cnt=0, op_q=0.
- **IDLE with START=1 and OP≤5**, at the next edge:
  - op_q←OP, VEC←0, cnt←0, ERR_CNT←0, FIRST_FAIL←0, PASS←0, BUSY←1.
  - State→RUN.
- **START with OP≥6**: ignored. No output changes.
- **START while in RUN**: ignored. The run is not restarted.
- **RUN, edge with cnt<SETTLE-1**: cnt←cnt+1.
- **RUN, edge with cnt==SETTLE-1** (sample edge), compare X against the expected value of VEC:
  - AND=&VEC, OR=|VEC, XOR=^VEC.
  - NAND, NOR and XNOR are the inversions of these.
  - On mismatch: ERR_CNT←ERR_CNT+1. If ERR_CNT was 0, FIRST_FAIL←VEC.
  - If VEC≠all-ones: VEC←VEC+1, cnt←0.
  - If VEC==all-ones: state→IDLE, BUSY←0, DONE←1 for exactly one cycle.
  - PASS←1 iff the final ERR_CNT (including this sample) is 0.
- **After a run**: VEC holds all-ones in IDLE until the next accepted START. ERR_CNT, FIRST_FAIL and PASS hold their values until then.
- **Width**: ERR_CNT maximum is 2^N_IN, so N_IN+1 bits never overflow. No saturation logic.
- **RST mid-run**: immediate return to reset values. DONE is not pulsed.
- **START in the same cycle as DONE**: START is accepted, because the state is already IDLE. The next run begins at the following edge.

## Timing

- START sampled at edge e0. VEC=0 is visible after e0.
- Each vector is held exactly SETTLE cycles. X is sampled at edges e0+k·SETTLE for k=1..2^N_IN.
- The last sample is at e0+2^N_IN·SETTLE. DONE is high in the cycle following that edge.
- BUSY is high for exactly 2^N_IN·SETTLE cycles.
- X must be stable by the end of the first cycle of each vector. The gate path is combinational, and SETTLE≥1 guarantees a full cycle.

## Structure

- **Package `gate_pkg`**:
  - OP encoding constants `OP_AND`..`OP_XNOR`.
  - `OP_W=3`.
  - State encoding `ST_IDLE`, `ST_RUN`.
  - Shared by future gate blocks and benches.
- **Sub-module `gate_ref_model`**: combinational, parameter N_IN, inputs `OP` and `VEC`, output `EXP`. It is reused by benches as a golden model.
- **Top**: FSM, settle counter, vector counter and result registers only.

## Test plan

- **Correct OR**: N_IN=2, SETTLE=4, OP=1, X=|VEC. Pulse START at e0.
  - Required: VEC steps 00→01→10→11 every 4 cycles, DONE at e0+16, PASS=1, ERR_CNT=0.
- **Stuck-at-0**: OP=1, X tied 0.
  - Required: ERR_CNT=3, FIRST_FAIL=01, PASS=0.
- **Wrong gate**: OP=4 (XOR), X=&VEC.
  - Required: mismatches at 01, 10 and 11. ERR_CNT=3, FIRST_FAIL=01, PASS=0.
- **Fast run**: N_IN=3, SETTLE=1, OP=5, X=~^VEC.
  - Required: 8 vectors on consecutive cycles, BUSY high for 8 cycles, DONE one cycle, PASS=1.
- **Reset and START abuse**, in sequence:
  - RST asserted at cycle 6 of a run → all outputs at reset values and no DONE.
  - START mid-run → ignored, so DONE timing is unchanged.
  - START with OP=7 → BUSY stays 0.
- **Back-to-back**: START held high through DONE.
  - Required: the second run starts at the edge after DONE. ERR_CNT and PASS are cleared at that edge.

Source files
------------

// File: rtl/gate_truth_checker_pkg.sv
// Shared definitions for the gate checking blocks: op encoding and sequencer states.
package gate_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_NAND = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

endpackage

// File: rtl/gate_truth_checker_ref.sv
// Golden combinational model of the library gates: expected output for a given op and input vector.
module gate_ref_model
    import gate_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [OP_W-1:0] OP,
    input  logic [N_IN-1:0] VEC,
    output logic            EXP
);

    always_comb begin
        EXP = 1'b0;
        case (OP)
            OP_AND:  EXP = &VEC;
            OP_OR:   EXP = |VEC;
            OP_NAND: EXP = ~&VEC;
            OP_NOR:  EXP = ~|VEC;
            OP_XOR:  EXP = ^VEC;
            OP_XNOR: EXP = ~^VEC;
            default: EXP = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_truth_checker.sv
// Truth-table sequencer: walks every input vector of a gate, samples its output after
// SETTLE cycles and accumulates mismatch count, first failing vector and pass flag.
module gate_truth_checker
    import gate_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [OP_W-1:0] OP,
    output logic [N_IN-1:0] VEC,
    input  logic            X,
    output logic            BUSY,
    output logic            DONE,
    output logic            PASS,
    output logic [N_IN:0]   ERR_CNT,
    output logic [N_IN-1:0] FIRST_FAIL
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [OP_W-1:0] op_q;
    logic            exp_bit;
    logic            mismatch;
    logic [N_IN:0]   err_next;

    gate_ref_model #(.N_IN(N_IN)) u_ref (
        .OP  (op_q),
        .VEC (VEC),
        .EXP (exp_bit)
    );

    always_comb begin
        mismatch = (X != exp_bit);
        err_next = ERR_CNT + {{N_IN{1'b0}}, mismatch};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            op_q       <= '0;
            VEC        <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            ERR_CNT    <= '0;
            FIRST_FAIL <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START && (OP <= OP_XNOR)) begin
                        op_q       <= OP;
                        VEC        <= '0;
                        cnt        <= '0;
                        ERR_CNT    <= '0;
                        FIRST_FAIL <= '0;
                        PASS       <= 1'b0;
                        BUSY       <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        if (mismatch) begin
                            ERR_CNT <= err_next;
                            if (ERR_CNT == '0) FIRST_FAIL <= VEC;
                        end
                        // VEC stays at all-ones after the final sample until the next run
                        if (&VEC) begin
                            state <= ST_IDLE;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            PASS  <= (err_next == '0);
                        end else begin
                            VEC <= VEC + 1'b1;
                            cnt <= '0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (N_IN=2/SETTLE=4 and N_IN=3/SETTLE=1)
// compared every cycle against a time-indexed behavioural model.
module tb_gate_truth_checker;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit gfn(input int op, input int v, input int n);
        int ones;
        ones = $countones(v);
        case (op)
            0: return ones == n;
            1: return ones != 0;
            2: return ones != n;
            3: return ones == 0;
            4: return ones % 2 == 1;
            5: return ones % 2 == 0;
            default: return 1'b0;
        endcase
    endfunction

    // ---------------- instance A: N_IN=2, SETTLE=4 ----------------
    logic       START_A = 1'b0;
    logic [2:0] OP_A = '0;
    logic [1:0] VEC_A;
    logic       X_A, BUSY_A, DONE_A, PASS_A;
    logic [2:0] ERR_A;
    logic [1:0] FF_A;
    int         xop_a = 1;
    bit         stuck_a = 1'b0, rnd_a = 1'b0, rbit_a = 1'b0;

    always_comb X_A = rnd_a ? rbit_a : (stuck_a ? 1'b0 : gfn(xop_a, int'(VEC_A), 2));

    gate_truth_checker #(.N_IN(2), .SETTLE(4)) dut_a (
        .CLK(CLK), .RST(RST), .START(START_A), .OP(OP_A), .VEC(VEC_A), .X(X_A),
        .BUSY(BUSY_A), .DONE(DONE_A), .PASS(PASS_A), .ERR_CNT(ERR_A), .FIRST_FAIL(FF_A)
    );

    // ---------------- instance B: N_IN=3, SETTLE=1 ----------------
    logic       START_B = 1'b0;
    logic [2:0] OP_B = '0;
    logic [2:0] VEC_B;
    logic       X_B, BUSY_B, DONE_B, PASS_B;
    logic [3:0] ERR_B;
    logic [2:0] FF_B;
    int         xop_b = 5;
    bit         rnd_b = 1'b0, rbit_b = 1'b0;

    always_comb X_B = rnd_b ? rbit_b : gfn(xop_b, int'(VEC_B), 3);

    gate_truth_checker #(.N_IN(3), .SETTLE(1)) dut_b (
        .CLK(CLK), .RST(RST), .START(START_B), .OP(OP_B), .VEC(VEC_B), .X(X_B),
        .BUSY(BUSY_B), .DONE(DONE_B), .PASS(PASS_B), .ERR_CNT(ERR_B), .FIRST_FAIL(FF_B)
    );

    always @(negedge CLK) begin
        rbit_a = $urandom_range(0, 1) == 1;
        rbit_b = $urandom_range(0, 1) == 1;
    end

    // ---------------- behavioural model ----------------
    // t counts cycles since the accepted START; vector k occupies t in [k*S, (k+1)*S).
    typedef struct {
        int busy; int done; int pass; int t; int vec; int err; int ff; int op;
    } model_t;

    function automatic model_t step(input model_t m, input bit start, input int op,
                                    input bit x, input int n, input int s);
        model_t r;
        int idx;
        r = m;
        r.done = 0;
        if (m.busy == 0) begin
            if (start && op <= 5) begin
                r = '{busy: 1, done: 0, pass: 0, t: 0, vec: 0, err: 0, ff: 0, op: op};
            end
        end else begin
            r.t = m.t + 1;
            if (r.t % s == 0) begin
                idx = r.t / s - 1;
                if (int'(x) != int'(gfn(m.op, idx, n))) begin
                    if (m.err == 0) r.ff = idx;
                    r.err = m.err + 1;
                end
                if (idx == (1 << n) - 1) begin
                    r.busy = 0;
                    r.done = 1;
                    r.pass = (r.err == 0) ? 1 : 0;
                end else begin
                    r.vec = r.t / s;
                end
            end
        end
        return r;
    endfunction

    model_t ma = '{default: 0};
    model_t mb = '{default: 0};

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            ma = '{default: 0};
            mb = '{default: 0};
        end else begin
            ma = step(ma, START_A, int'(OP_A), X_A, 2, 4);
            mb = step(mb, START_B, int'(OP_B), X_B, 3, 1);
        end
    end

    always @(negedge CLK) begin
        chk("A_vec",  int'(VEC_A),  ma.vec);
        chk("A_busy", int'(BUSY_A), ma.busy);
        chk("A_done", int'(DONE_A), ma.done);
        chk("A_pass", int'(PASS_A), ma.pass);
        chk("A_err",  int'(ERR_A),  ma.err);
        if (ma.err != 0) chk("A_ff", int'(FF_A), ma.ff);
        chk("B_vec",  int'(VEC_B),  mb.vec);
        chk("B_busy", int'(BUSY_B), mb.busy);
        chk("B_done", int'(DONE_B), mb.done);
        chk("B_pass", int'(PASS_B), mb.pass);
        chk("B_err",  int'(ERR_B),  mb.err);
        if (mb.err != 0) chk("B_ff", int'(FF_B), mb.ff);
    end

    int done_cnt_a = 0;
    always @(negedge CLK) if (DONE_A) done_cnt_a++;

    // ---------------- stimulus helpers ----------------
    task automatic start_a(input int op, output int e0);
        @(negedge CLK);
        START_A = 1'b1;
        OP_A = 3'(op);
        @(posedge CLK);
        #1;
        e0 = cyc;
        START_A = 1'b0;
    endtask

    task automatic wait_done_a(output int dcyc);
        int i;
        dcyc = -1;
        for (i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (DONE_A) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) chk("A_done_timeout", 0, 1);
    endtask

    initial begin
        int e0, dc, busy_cnt, dsave;
        repeat (3) @(negedge CLK);
        chk("reset_vec", int'(VEC_A), 0);
        chk("reset_busy", int'(BUSY_A), 0);
        @(posedge CLK);
        #2 RST = 1'b0;

        // Correct OR
        xop_a = 1; stuck_a = 0; rnd_a = 0;
        start_a(1, e0);
        wait_done_a(dc);
        chk("or_done_cycle", dc - e0, 16);
        chk("or_pass", int'(PASS_A), 1);
        chk("or_err", int'(ERR_A), 0);
        chk("or_vec_hold", int'(VEC_A), 3);

        // Stuck-at-0 against OR
        stuck_a = 1;
        start_a(1, e0);
        wait_done_a(dc);
        chk("stuck_err", int'(ERR_A), 3);
        chk("stuck_ff", int'(FF_A), 1);
        chk("stuck_pass", int'(PASS_A), 0);
        stuck_a = 0;

        // Wrong gate: expect XOR, gate is AND
        xop_a = 0;
        start_a(4, e0);
        wait_done_a(dc);
        chk("wrong_err", int'(ERR_A), 3);
        chk("wrong_ff", int'(FF_A), 1);
        chk("wrong_pass", int'(PASS_A), 0);

        // Fast run on B: XNOR, correct gate
        xop_b = 5;
        @(negedge CLK);
        START_B = 1'b1; OP_B = 3'd5;
        @(posedge CLK);
        #1 e0 = cyc; START_B = 1'b0;
        busy_cnt = 0; dc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (BUSY_B) busy_cnt++;
            if (DONE_B) begin dc = cyc; break; end
        end
        chk("fast_busy_cycles", busy_cnt, 8);
        chk("fast_done_cycle", dc - e0, 8);
        chk("fast_pass", int'(PASS_B), 1);
        @(negedge CLK);
        chk("fast_done_pulse", int'(DONE_B), 0);

        // Reset at cycle 6 of a run
        xop_a = 1;
        start_a(1, e0);
        repeat (6) @(negedge CLK);
        dsave = done_cnt_a;
        @(posedge CLK);
        #2 RST = 1'b1;
        @(posedge CLK);
        #2 RST = 1'b0;
        repeat (20) @(negedge CLK);
        chk("rst_no_done", done_cnt_a, dsave);
        chk("rst_busy", int'(BUSY_A), 0);
        chk("rst_vec", int'(VEC_A), 0);
        chk("rst_pass", int'(PASS_A), 0);

        // START mid-run is ignored
        start_a(1, e0);
        repeat (5) @(negedge CLK);
        START_A = 1'b1; OP_A = 3'd2;
        @(negedge CLK);
        START_A = 1'b0;
        wait_done_a(dc);
        chk("midstart_done_cycle", dc - e0, 16);
        chk("midstart_pass", int'(PASS_A), 1);

        // Invalid op
        @(negedge CLK);
        START_A = 1'b1; OP_A = 3'd7;
        repeat (3) @(negedge CLK);
        chk("badop_busy", int'(BUSY_A), 0);
        START_A = 1'b0;

        // Back-to-back with START held high
        stuck_a = 1;
        @(negedge CLK);
        START_A = 1'b1; OP_A = 3'd1;
        wait_done_a(dc);
        chk("b2b_first_err", int'(ERR_A), 3);
        @(negedge CLK);
        START_A = 1'b0;
        chk("b2b_restart_busy", int'(BUSY_A), 1);
        chk("b2b_restart_err", int'(ERR_A), 0);
        chk("b2b_restart_vec", int'(VEC_A), 0);
        wait_done_a(dc);
        stuck_a = 0;

        // Randomised runs on both instances
        rnd_a = 1; rnd_b = 1;
        for (int k = 0; k < 12; k++) begin
            int opa, opb;
            opa = $urandom_range(0, 7);
            opb = $urandom_range(0, 7);
            @(negedge CLK);
            START_A = 1'b1; OP_A = 3'(opa);
            START_B = 1'b1; OP_B = 3'(opb);
            @(negedge CLK);
            START_A = 1'b0; START_B = 1'b0;
            repeat (24) @(negedge CLK);
        end
        rnd_a = 0; rnd_b = 0;
        repeat (4) @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
